// File: rtl/data_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_pkg : shared types and constants for the data memory responder     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] MMIO_ADDR           = 32'hFFFF_FF00;
  localparam int          DEFAULT_DEPTH_WORDS = 256;
  localparam int          DEFAULT_WAIT_CYCLES = 2;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_responder_if : pipeline memory-stage request/response bus          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface data_mem_responder_if;
  import data_mem_pkg::*;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        stall;
  logic        err;

  modport master (
    output mem_req, mem_we, addr, wdata,
    input  rdata, mem_ready, stall, err
  );

  modport slave (
    input  mem_req, mem_we, addr, wdata,
    output rdata, mem_ready, stall, err
  );

endinterface
`default_nettype wire

// File: rtl/ram_sp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_sp : single-port synchronous RAM, read data registered on enabled read  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ram_sp
  import data_mem_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH_WORDS,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              en,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [WIDTH-1:0]  wdata,
  output logic      [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Output register only moves on reads so it holds across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        rdata <= r_mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_responder : wait-state data memory with optional MMIO register     |
// | Optional feature macro: DATA_MEM_MMIO_EN (adds io_out at 32'hFFFF_FF00)     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  wire logic            clk,
  input  wire logic            reset,
  data_mem_responder_if.slave  bus
`ifdef DATA_MEM_MMIO_EN
  ,
  output logic [31:0]          io_out
`endif
);

  localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            r_state, w_state_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_idx;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic              r_oor;
  logic              r_mmio;
  logic              r_use_ram;
  logic [31:0]       r_alt_rdata;
  logic [31:0]       w_ram_rdata;
  logic [31:0]       w_io_value;

  logic              w_accept, w_in_range, w_mmio_hit, w_oor;
  logic [ADDR_W-1:0] w_cur_idx;
  logic              w_cur_we, w_cur_oor, w_cur_mmio;
  logic [31:0]       w_cur_wdata;
  logic              w_enter_done, w_commit, w_ready;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.addr[1:0];

  assign w_accept   = (r_state == IDLE) && bus.mem_req;
  assign w_in_range = (bus.addr[31:ADDR_W+2] == '0);
`ifdef DATA_MEM_MMIO_EN
  assign w_mmio_hit = (bus.addr[31:2] == MMIO_ADDR[31:2]);
`else
  assign w_mmio_hit = 1'b0;
`endif
  assign w_oor      = !w_in_range && !w_mmio_hit;

  // With zero wait states the access completes on the accepting edge, so the
  // live bus values drive that commit; later commits use the latched copy.
  assign w_cur_idx   = (r_state == IDLE) ? bus.addr[ADDR_W+1:2] : r_idx;
  assign w_cur_we    = (r_state == IDLE) ? bus.mem_we           : r_we;
  assign w_cur_wdata = (r_state == IDLE) ? bus.wdata            : r_wdata;
  assign w_cur_oor   = (r_state == IDLE) ? w_oor                : r_oor;
  assign w_cur_mmio  = (r_state == IDLE) ? w_mmio_hit           : r_mmio;

  assign w_enter_done = (w_accept && !HAS_WAIT) || ((r_state == BUSY) && (r_cnt == 4'd0));
  assign w_commit     = w_enter_done && !reset;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.mem_req) begin
          if (HAS_WAIT) begin
            w_state_next = BUSY;
            w_cnt_next   = CNT_INIT;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_next = DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= bus.addr[ADDR_W+1:2];
      r_we    <= bus.mem_we;
      r_wdata <= bus.wdata;
      r_oor   <= w_oor;
      r_mmio  <= w_mmio_hit;
    end
  end

  ram_sp #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (32)
  ) u_ram (
    .clk   (clk),
    .en    (w_commit && !w_cur_oor && !w_cur_mmio),
    .we    (w_cur_we),
    .addr  (w_cur_idx),
    .wdata (w_cur_wdata),
    .rdata (w_ram_rdata)
  );

`ifdef DATA_MEM_MMIO_EN
  logic [31:0] r_io;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_io <= 32'd0;
    end else if (w_commit && w_cur_we && w_cur_mmio) begin
      r_io <= w_cur_wdata;
    end
  end

  assign io_out     = r_io;
  assign w_io_value = r_io;
`else
  assign w_io_value = 32'd0;
`endif

  // rdata is either the RAM output register or a captured zero / MMIO value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_use_ram   <= 1'b0;
      r_alt_rdata <= 32'd0;
    end else if (w_commit && !w_cur_we) begin
      if (w_cur_oor) begin
        r_use_ram   <= 1'b0;
        r_alt_rdata <= 32'd0;
      end else if (w_cur_mmio) begin
        r_use_ram   <= 1'b0;
        r_alt_rdata <= w_io_value;
      end else begin
        r_use_ram   <= 1'b1;
      end
    end
  end

  assign w_ready       = (r_state == DONE);
  assign bus.mem_ready = w_ready;
  assign bus.err       = w_ready && r_oor;
  assign bus.rdata     = r_use_ram ? w_ram_rdata : r_alt_rdata;
  assign bus.stall     = bus.mem_req && !w_ready;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_mem_responder : directed vectors on WAIT_CYCLES=2 and =0 instances  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_data_mem_responder;
  import data_mem_pkg::*;

`ifdef DATA_MEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst0, rst2;
  always #5 clk = ~clk;

  data_mem_responder_if b0 ();
  data_mem_responder_if b2 ();
`ifdef DATA_MEM_MMIO_EN
  logic [31:0] io0, io2;
`endif

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (b2)
`ifdef DATA_MEM_MMIO_EN
    , .io_out (io2)
`endif
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (b0)
`ifdef DATA_MEM_MMIO_EN
    , .io_out (io0)
`endif
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      b0.mem_req = req; b0.mem_we = we; b0.addr = a; b0.wdata = d;
    end else begin
      b2.mem_req = req; b2.mem_we = we; b2.addr = a; b2.wdata = d;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? b0.mem_ready : b2.mem_ready;
  endfunction
  function automatic logic get_stall(input int sel);
    return (sel == 0) ? b0.stall : b2.stall;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? b0.err : b2.err;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? b0.rdata : b2.rdata;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the DONE cycle (or one cycle
  // later, back in IDLE, when keep=0). lat counts edges to mem_ready.
  task automatic acc(input int sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input bit keep, output logic [31:0] rd, output logic e,
                     output int lat, output int stalls);
    bit done;
    done = 1'b0; lat = 0; stalls = 0; rd = '0; e = 1'b0;
    drive(sel, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (get_stall(sel)) stalls++;
      @(posedge clk); #1;
      lat++;
      if (get_ready(sel)) begin
        rd = get_rdata(sel);
        e  = get_err(sel);
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      $display("FAIL timeout dut%0d addr=%h actual=no_ready required=ready", sel, a);
    end
    if (!keep) begin
      drive(sel, 1'b0, we, a, d);
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat, stalls;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'hCAFE_F00D, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_03FE, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'hA5A5_A5A5, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FF00, 32'h0000_005A, 32'h0BAD_F00D, !MMIO_ON};
    vecs[11] = '{1'b0, 32'hFFFF_FF00, 32'h0,         MMIO_ON ? 32'h5A : 32'h0, !MMIO_ON};
    vecs[12] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0};

    rst0 = 1'b1; rst2 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready2", {31'b0, b2.mem_ready}, 32'd0);
    check("rst_err2",   {31'b0, b2.err},       32'd0);
    check("rst_rdata2", b2.rdata,              32'd0);
    check("rst_stall2", {31'b0, b2.stall},     32'd0);
    check("rst_ready0", {31'b0, b0.mem_ready}, 32'd0);
    check("rst_rdata0", b0.rdata,              32'd0);
`ifdef DATA_MEM_MMIO_EN
    check("rst_io2", io2, 32'd0);
`endif
    rst0 = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;

    // Table-driven accesses, WAIT_CYCLES=2, request dropped after each ready.
    for (int i = 0; i < 13; i++) begin
      acc(2, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, rd, e, lat, stalls);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_stall", i), 32'(stalls), 32'd3);
    end
`ifdef DATA_MEM_MMIO_EN
    check("mmio_io_out", io2, 32'h0000_005A);
`endif

    // Address/data change and request drop mid-BUSY: latched write must land.
    acc(2, 1'b1, 32'h44, 32'h4444_4444, 1'b0, rd, e, lat, stalls);
    drive(2, 1'b1, 1'b1, 32'h40, 32'h7777_7777);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 32'h44, 32'h8888_8888);
    lat = 1;
    for (int i = 0; i < 10 && !b2.mem_ready; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    check("midbusy_lat", 32'(lat), 32'd3);
    check("midbusy_err", {31'b0, b2.err}, 32'd0);
    @(posedge clk); #1;
    acc(2, 1'b0, 32'h40, 32'h0, 1'b0, rd, e, lat, stalls);
    check("midbusy_rd40", rd, 32'h7777_7777);
    acc(2, 1'b0, 32'h44, 32'h0, 1'b0, rd, e, lat, stalls);
    check("midbusy_rd44", rd, 32'h4444_4444);

    // Reset in the second BUSY cycle aborts the write.
    acc(2, 1'b1, 32'h20, 32'h1111_1111, 1'b0, rd, e, lat, stalls);
    drive(2, 1'b1, 1'b1, 32'h20, 32'h2222_2222);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    check("abort_state", {30'b0, dut2.r_state}, {30'b0, IDLE});
    check("abort_ready", {31'b0, b2.mem_ready}, 32'd0);
    check("abort_rdata", b2.rdata, 32'd0);
    check("abort_err",   {31'b0, b2.err}, 32'd0);
`ifdef DATA_MEM_MMIO_EN
    check("abort_io", io2, 32'd0);
`endif
    @(posedge clk); #1;
    check("abort_no_ready", {31'b0, b2.mem_ready}, 32'd0);
    acc(2, 1'b0, 32'h20, 32'h0, 1'b0, rd, e, lat, stalls);
    check("abort_rd20", rd, 32'h1111_1111);

    // WAIT_CYCLES=0: prep write, then read/write/read with request held.
    acc(0, 1'b1, 32'h8, 32'h0F0F_0F0F, 1'b0, rd, e, lat, stalls);
    check("w0_prep_lat", 32'(lat), 32'd1);
    check("w0_prep_rd", rd, 32'd0);
    acc(0, 1'b0, 32'h8, 32'h0, 1'b1, rd, e, lat, stalls);
    check("w0_rd1", rd, 32'h0F0F_0F0F);
    check("w0_rd1_lat", 32'(lat), 32'd1);
    check("w0_rd1_stall", 32'(stalls), 32'd1);
    acc(0, 1'b1, 32'h8, 32'hF0F0_F0F0, 1'b1, rd, e, lat, stalls);
    check("w0_wr_hold", rd, 32'h0F0F_0F0F);
    check("w0_wr_lat", 32'(lat), 32'd2);
    check("w0_wr_stall", 32'(stalls), 32'd1);
    acc(0, 1'b0, 32'h8, 32'h0, 1'b0, rd, e, lat, stalls);
    check("w0_rd2", rd, 32'hF0F0_F0F0);
    check("w0_rd2_lat", 32'(lat), 32'd2);
    check("w0_rd2_err", {31'b0, e}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, sets the number of 32-bit words in the array; SHALL be a power of two from 16 to 4096.
REQ-002 Parameter WAIT_CYCLES, default 2, sets the wait states inserted per access; legal range is 0..15.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is a synchronous, active-high reset.
REQ-005 Port mem_req  input  1  is the access request from the pipeline memory stage; it is held high until mem_ready.
REQ-006 Port mem_we  input  1  selects the access type: 1 = write, 0 = read.
REQ-007 Port addr  input  32  is the byte address, driven from the pipeline ALU output.
REQ-008 Port wdata  input  32  is the write data.
REQ-009 Port rdata  output  32  is the read data, valid while mem_ready is high.
REQ-010 Port mem_ready  output  1  is a one-cycle completion pulse.
REQ-011 Port stall  output  1  is the stall request to the hazard logic.
REQ-012 Port err  output  1  is an out-of-range flag that pulses together with mem_ready.
REQ-013 Port io_out  output  32  is the MMIO output register; it is present only when DATA_MEM_MMIO_EN is defined.

Function
REQ-014 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] SHALL be ignored.
REQ-015 The FSM SHALL have three states:
- IDLE: on mem_req=1, latch addr, mem_we and wdata; go to BUSY if WAIT_CYCLES>0, else go to DONE.
- BUSY: count down from WAIT_CYCLES-1; go to DONE when the count reaches 0.
- DONE: go to IDLE unconditionally.
REQ-016 The latency from the accepting edge in IDLE to mem_ready high SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-017 mem_ready SHALL be high only in DONE, for exactly one cycle per request.
REQ-018 Changes on addr, mem_we or wdata after acceptance SHALL be ignored; the latched values are used.
REQ-019 A write SHALL commit on the edge entering DONE.
REQ-020 For a read, rdata SHALL be loaded on the edge entering DONE and held until the next DONE.
REQ-021 For a write, rdata SHALL hold its previous value.
REQ-022 stall SHALL be combinational: mem_req && !mem_ready.
REQ-023 Requests are sampled only in IDLE; back-to-back requests SHALL therefore incur one IDLE cycle, with stall high during it.
REQ-024 mem_req=0 in IDLE SHALL leave the state unchanged.
REQ-025 mem_req dropping during BUSY SHALL NOT abort the access; it completes normally.
REQ-026 An out-of-range access (addr >= 4*DEPTH_WORDS and not an MMIO hit) SHALL:
- perform no write;
- load rdata with 0;
- assert err with mem_ready.
REQ-027 err SHALL be 0 in every other cycle.

Reset
REQ-028 When reset=1 at a clock edge, the block SHALL set state=IDLE, counter=0, mem_ready=0, err=0 and rdata=0, and io_out=0 when present.
REQ-029 Reset during BUSY or DONE SHALL abort the access with no array write.
REQ-030 reset SHALL take priority over mem_req on the same edge.
REQ-031 Array contents SHALL NOT be reset.

Configuration
REQ-032 With DATA_MEM_MMIO_EN defined:
- byte address 32'hFFFF_FF00 maps to the io_out register;
- writes update io_out in DONE;
- reads return io_out;
- err stays 0;
- timing is identical to array accesses.
REQ-033 Without DATA_MEM_MMIO_EN, the io_out port and register SHALL be absent, and 32'hFFFF_FF00 is out of range (err=1).

Structure
REQ-034 Package data_mem_pkg SHALL hold:
- the FSM state enum (IDLE, BUSY, DONE);
- MMIO_ADDR = 32'hFFFF_FF00;
- default DEPTH_WORDS and WAIT_CYCLES.
REQ-035 The array SHALL be a sub-module ram_sp: single-port, synchronous read/write, one write enable, parameterised by depth.

Verification
REQ-036 WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 with req held.
- mem_ready SHALL go high exactly 3 cycles after acceptance.
- stall SHALL be high during the 3 preceding cycles.
- A subsequent read of 0x10 SHALL return 0xDEADBEEF.
REQ-037 WAIT_CYCLES=0: read, then immediately write, then read the same word.
- Each mem_ready SHALL arrive 1 cycle after its acceptance.
- There SHALL be one idle cycle between accesses.
- The final read SHALL return the written data.
REQ-038 Read of address 0x400 with DEPTH_WORDS=256 SHALL return rdata=0 and err=1 with mem_ready; an earlier write there SHALL leave the array unchanged.
REQ-039 Assert reset in the second BUSY cycle of a write to 0x20 holding 0x1111_1111 (new data 0x2222_2222).
- Next cycle SHALL show state IDLE, ready=0 and rdata=0.
- A read of 0x20 SHALL return 0x1111_1111.
REQ-040 With DATA_MEM_MMIO_EN defined, write 0x5A to 0xFFFF_FF00: io_out SHALL equal 0x5A after the DONE edge and err SHALL be 0. Without the macro, the same access SHALL give err=1.
REQ-041 Change addr and wdata mid-BUSY: the write SHALL use the values latched at acceptance.
